// File: rtl/board_token_controller.sv
// Multi-player board token controller: accepts move commands over a
// valid/ready handshake and animates the selected token tile by tile
// (slide, then hop), advancing only on frame_tick.
module board_token_controller #(
    parameter int unsigned NUM_PLAYERS   = 2,
    parameter int unsigned NUM_TILES     = 10,
    parameter int unsigned TILE_SIZE     = 48,
    parameter int unsigned PLAYER_OFFSET = 16,
    parameter int unsigned BASE_Y        = 124,
    parameter int unsigned MOVE_FRAMES   = 24,
    parameter int unsigned JUMP_FRAMES   = 16,
    parameter int unsigned JUMP_HEIGHT   = 32,
    parameter int unsigned WRAP          = 1,
    localparam int unsigned PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
    localparam int unsigned TW = $clog2(NUM_TILES)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_tick,
    input  logic                      move_valid,
    output logic                      move_ready,
    input  logic [PW-1:0]             move_player,
    input  logic [3:0]                move_steps,
    output logic                      move_done,
    output logic                      cmd_err,
    output logic [PW-1:0]             active_player,
    output logic                      busy,
    output logic [NUM_PLAYERS*10-1:0] player_x,
    output logic [NUM_PLAYERS*10-1:0] player_y,
    output logic [NUM_PLAYERS*TW-1:0] player_tile,
    output logic [NUM_PLAYERS*4-1:0]  player_laps,
    output logic [NUM_PLAYERS-1:0]    finished
);

    localparam int unsigned MAXF = (MOVE_FRAMES > JUMP_FRAMES) ? MOVE_FRAMES : JUMP_FRAMES;
    localparam int unsigned CW   = $clog2(MAXF);
    localparam logic [TW-1:0] LAST_TILE = TW'(NUM_TILES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_HOP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic [CW-1:0]                  counter_q, counter_d;
    logic [PW-1:0]                  player_q, player_d;
    logic [3:0]                     steps_left_q, steps_left_d;
    logic                           err_q, err_d;
    logic [9:0]                     start_x_q, start_x_d;
    logic [TW-1:0]                  target_tile_q, target_tile_d;
    logic [9:0]                     target_x_q, target_x_d;
    logic [NUM_PLAYERS-1:0][TW-1:0] tile_q, tile_d;
    logic [NUM_PLAYERS-1:0][3:0]    lap_q, lap_d;
    logic [NUM_PLAYERS-1:0]         fin_q, fin_d;
    logic [NUM_PLAYERS-1:0][9:0]    x_q, x_d;
    logic [NUM_PLAYERS-1:0][9:0]    y_q, y_d;
    logic                           ready_q, done_q, cerr_q, busy_q;

    logic [TW-1:0]                  sel_tile_c, act_tile_c;
    logic                           sel_fin_c, act_fin_c, bad_idx_c;

    function automatic logic [9:0] tile_to_x(input logic [TW-1:0] t);
        return 10'(32'(t) * TILE_SIZE + PLAYER_OFFSET);
    endfunction

    function automatic logic [TW-1:0] next_tile(input logic [TW-1:0] t);
        if (t == LAST_TILE) return (WRAP != 0) ? '0 : t;
        return t + TW'(1);
    endfunction

    // Linear interpolation between start and target x; signed so a wrap step slides left.
    function automatic logic [9:0] slide_x(input logic [9:0] sx, input logic [9:0] tx,
                                           input logic [CW-1:0] c);
        logic signed [11:0] diff;
        logic signed [23:0] prod;
        diff = $signed({2'b00, tx}) - $signed({2'b00, sx});
        prod = 24'(diff) * $signed(24'(c));
        return 10'($signed({14'd0, sx}) + prod / $signed(24'(MOVE_FRAMES)));
    endfunction

    // Triangular hop profile peaking at JUMP_HEIGHT mid-hop.
    function automatic logic [9:0] hop_y(input logic [CW-1:0] c);
        int unsigned ci;
        int unsigned h;
        ci = 32'(c);
        if (ci < JUMP_FRAMES / 2) h = ci * 2 * JUMP_HEIGHT / JUMP_FRAMES;
        else                      h = (JUMP_FRAMES - ci) * 2 * JUMP_HEIGHT / JUMP_FRAMES;
        return 10'(BASE_Y - h);
    endfunction

    assign bad_idx_c = (32'(move_player) >= NUM_PLAYERS);

    // Look up the tile/finished state of the requested and the active token.
    always_comb begin
        sel_tile_c = '0;
        sel_fin_c  = 1'b0;
        act_tile_c = '0;
        act_fin_c  = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (move_player == PW'(p)) begin
                sel_tile_c = tile_q[p];
                sel_fin_c  = fin_q[p];
            end
            if (player_q == PW'(p)) begin
                act_tile_c = tile_q[p];
                act_fin_c  = fin_q[p];
            end
        end
    end

    // Next-state logic: command acceptance, frame pacing and tile landing.
    always_comb begin
        state_d       = state_q;
        counter_d     = counter_q;
        player_d      = player_q;
        steps_left_d  = steps_left_q;
        err_d         = err_q;
        start_x_d     = start_x_q;
        target_tile_d = target_tile_q;
        target_x_d    = target_x_q;
        tile_d        = tile_q;
        lap_d         = lap_q;
        fin_d         = fin_q;
        unique case (state_q)
            S_IDLE: begin
                if (move_valid) begin
                    player_d     = move_player;
                    steps_left_d = move_steps;
                    err_d        = bad_idx_c;
                    counter_d    = '0;
                    if (move_steps == 4'd0 || bad_idx_c ||
                        (WRAP == 0 && (sel_fin_c || sel_tile_c == LAST_TILE))) begin
                        state_d = S_DONE;
                    end else begin
                        state_d       = S_MOVE;
                        start_x_d     = tile_to_x(sel_tile_c);
                        target_tile_d = next_tile(sel_tile_c);
                        target_x_d    = tile_to_x(next_tile(sel_tile_c));
                    end
                end
            end
            S_MOVE: begin
                if (frame_tick) begin
                    if (counter_q == CW'(MOVE_FRAMES - 1)) begin
                        counter_d = '0;
                        state_d   = S_HOP;
                        for (int p = 0; p < NUM_PLAYERS; p++) begin
                            if (player_q == PW'(p)) begin
                                tile_d[p] = target_tile_q;
                                if (WRAP != 0 && target_tile_q == '0)
                                    lap_d[p] = (lap_q[p] == 4'd15) ? 4'd15 : lap_q[p] + 4'd1;
                                if (WRAP == 0 && target_tile_q == LAST_TILE)
                                    fin_d[p] = 1'b1;
                            end
                        end
                    end else begin
                        counter_d = counter_q + CW'(1);
                    end
                end
            end
            S_HOP: begin
                if (frame_tick) begin
                    if (counter_q == CW'(JUMP_FRAMES - 1)) begin
                        counter_d    = '0;
                        steps_left_d = steps_left_q - 4'd1;
                        if (steps_left_q == 4'd1 || act_fin_c) begin
                            state_d = S_DONE;
                        end else begin
                            state_d       = S_MOVE;
                            start_x_d     = tile_to_x(act_tile_c);
                            target_tile_d = next_tile(act_tile_c);
                            target_x_d    = tile_to_x(next_tile(act_tile_c));
                        end
                    end else begin
                        counter_d = counter_q + CW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pixel positions for the next cycle, derived from the next state.
    always_comb begin
        x_d = '0;
        y_d = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            x_d[p] = tile_to_x(tile_d[p]);
            y_d[p] = 10'(BASE_Y);
            if (player_d == PW'(p)) begin
                if (state_d == S_MOVE) x_d[p] = slide_x(start_x_d, target_x_d, counter_d);
                if (state_d == S_HOP)  y_d[p] = hop_y(counter_d);
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            counter_q     <= '0;
            player_q      <= '0;
            steps_left_q  <= '0;
            err_q         <= 1'b0;
            start_x_q     <= 10'(PLAYER_OFFSET);
            target_tile_q <= '0;
            target_x_q    <= 10'(PLAYER_OFFSET);
            tile_q        <= '0;
            lap_q         <= '0;
            fin_q         <= '0;
            x_q           <= {NUM_PLAYERS{10'(PLAYER_OFFSET)}};
            y_q           <= {NUM_PLAYERS{10'(BASE_Y)}};
            ready_q       <= 1'b1;
            done_q        <= 1'b0;
            cerr_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            player_q      <= player_d;
            steps_left_q  <= steps_left_d;
            err_q         <= err_d;
            start_x_q     <= start_x_d;
            target_tile_q <= target_tile_d;
            target_x_q    <= target_x_d;
            tile_q        <= tile_d;
            lap_q         <= lap_d;
            fin_q         <= fin_d;
            x_q           <= x_d;
            y_q           <= y_d;
            ready_q       <= (state_d == S_IDLE);
            done_q        <= (state_d == S_DONE);
            cerr_q        <= (state_d == S_DONE) && err_d;
            busy_q        <= (state_d != S_IDLE);
        end
    end

    assign move_ready    = ready_q;
    assign move_done     = done_q;
    assign cmd_err       = cerr_q;
    assign busy          = busy_q;
    assign active_player = player_q;
    assign player_x      = x_q;
    assign player_y      = y_q;
    assign player_tile   = tile_q;
    assign player_laps   = lap_q;
    assign finished      = fin_q;

endmodule

// File: tb/tb_board_token_controller.sv
// Bench for board_token_controller: a wrapping 2-player instance and a
// clamping 3-player instance share one command stream; both are compared
// every cycle against an elapsed-tick reference model.
module tb_board_token_controller;

    localparam int NT = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        move_valid = 1'b0;
    logic [1:0]  mp = '0;
    logic [3:0]  move_steps = '0;

    logic        r0, d0, e0, b0;
    logic [0:0]  a0;
    logic [19:0] x0, y0;
    logic [7:0]  t0, l0;
    logic [1:0]  f0;

    logic        r1, d1, e1, b1;
    logic [1:0]  a1;
    logic [29:0] x1, y1;
    logic [11:0] t1, l1;
    logic [2:0]  f1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    board_token_controller #(.NUM_PLAYERS(2), .WRAP(1)) u0 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .move_valid(move_valid), .move_ready(r0), .move_player(mp[0:0]),
        .move_steps(move_steps), .move_done(d0), .cmd_err(e0),
        .active_player(a0), .busy(b0), .player_x(x0), .player_y(y0),
        .player_tile(t0), .player_laps(l0), .finished(f0)
    );

    board_token_controller #(.NUM_PLAYERS(3), .WRAP(0)) u1 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .move_valid(move_valid), .move_ready(r1), .move_player(mp),
        .move_steps(move_steps), .move_done(d1), .cmd_err(e1),
        .active_player(a1), .busy(b1), .player_x(x1), .player_y(y1),
        .player_tile(t1), .player_laps(l1), .finished(f1)
    );

    // Reference model: phase 0 idle, 1 animating, 2 done; progress is ticks since accept.
    int m_tile [2][4];
    int m_lap  [2][4];
    bit m_fin  [2][4];
    int m_phase[2];
    int m_act  [2];
    bit m_err  [2];
    int m_ticks[2];
    int m_eff  [2];

    function automatic int np(int i);   return (i == 0) ? 2 : 3; endfunction
    function automatic bit wrap(int i); return (i == 0);         endfunction
    function automatic int to_x(int t); return 16 + 48 * t;      endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 4; p++) begin
                m_tile[i][p] = 0; m_lap[i][p] = 0; m_fin[i][p] = 1'b0;
            end
            m_phase[i] = 0; m_act[i] = 0; m_err[i] = 1'b0; m_ticks[i] = 0; m_eff[i] = 0;
        end
    endtask

    task automatic model_step(int i, bit v, int pl, int st, bit tk);
        int pi;
        int p;
        pi = (i == 0) ? pl % 2 : pl;
        case (m_phase[i])
            0: if (v) begin
                m_act[i]   = pi;
                m_err[i]   = (pi >= np(i));
                m_ticks[i] = 0;
                if (m_err[i] || st == 0)       m_eff[i] = 0;
                else if (wrap(i))              m_eff[i] = st;
                else if (st < NT - 1 - m_tile[i][pi]) m_eff[i] = st;
                else                           m_eff[i] = NT - 1 - m_tile[i][pi];
                m_phase[i] = (m_eff[i] == 0) ? 2 : 1;
            end
            1: if (tk) begin
                m_ticks[i]++;
                p = m_act[i];
                if (m_ticks[i] % 40 == 24) begin
                    if (m_tile[i][p] == NT - 1) begin
                        m_tile[i][p] = 0;
                        if (m_lap[i][p] < 15) m_lap[i][p]++;
                    end else begin
                        m_tile[i][p]++;
                    end
                    if (!wrap(i) && m_tile[i][p] == NT - 1) m_fin[i][p] = 1'b1;
                end
                if (m_ticks[i] == m_eff[i] * 40) m_phase[i] = 2;
            end
            default: m_phase[i] = 0;
        endcase
    endtask

    function automatic logic [63:0] exp_x(int i);
        logic [63:0] v;
        v = '0;
        for (int p = 0; p < np(i); p++) begin
            int x;
            int w;
            int nt;
            x = to_x(m_tile[i][p]);
            if (m_phase[i] == 1 && m_act[i] == p) begin
                w = m_ticks[i] % 40;
                if (w < 24) begin
                    nt = (m_tile[i][p] == NT - 1) ? 0 : m_tile[i][p] + 1;
                    x = to_x(m_tile[i][p]) + (to_x(nt) - to_x(m_tile[i][p])) * w / 24;
                end
            end
            v[p*10 +: 10] = 10'(x);
        end
        return v;
    endfunction

    function automatic logic [63:0] exp_y(int i);
        logic [63:0] v;
        v = '0;
        for (int p = 0; p < np(i); p++) begin
            int y;
            int c;
            y = 124;
            if (m_phase[i] == 1 && m_act[i] == p && m_ticks[i] % 40 >= 24) begin
                c = m_ticks[i] % 40 - 24;
                y = 124 - ((c < 8) ? c * 64 / 16 : (16 - c) * 64 / 16);
            end
            v[p*10 +: 10] = 10'(y);
        end
        return v;
    endfunction

    function automatic logic [63:0] exp_field(int i, int sel);
        logic [63:0] v;
        v = '0;
        for (int p = 0; p < np(i); p++) begin
            if (sel == 0) v[p*4 +: 4] = 4'(m_tile[i][p]);
            if (sel == 1) v[p*4 +: 4] = 4'(m_lap[i][p]);
            if (sel == 2) v[p] = m_fin[i][p];
        end
        return v;
    endfunction

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
            if (errors > 40) finish_run();
        end
    endtask

    task automatic compare_all();
        check("u0_ready", 64'(r0), 64'(m_phase[0] == 0));
        check("u0_busy",  64'(b0), 64'(m_phase[0] != 0));
        check("u0_done",  64'(d0), 64'(m_phase[0] == 2));
        check("u0_err",   64'(e0), 64'(m_phase[0] == 2 && m_err[0]));
        check("u0_act",   64'(a0), 64'(m_act[0]));
        check("u0_x",     64'(x0), exp_x(0));
        check("u0_y",     64'(y0), exp_y(0));
        check("u0_tile",  64'(t0), exp_field(0, 0));
        check("u0_laps",  64'(l0), exp_field(0, 1));
        check("u0_fin",   64'(f0), exp_field(0, 2));
        check("u1_ready", 64'(r1), 64'(m_phase[1] == 0));
        check("u1_busy",  64'(b1), 64'(m_phase[1] != 0));
        check("u1_done",  64'(d1), 64'(m_phase[1] == 2));
        check("u1_err",   64'(e1), 64'(m_phase[1] == 2 && m_err[1]));
        check("u1_act",   64'(a1), 64'(m_act[1]));
        check("u1_x",     64'(x1), exp_x(1));
        check("u1_y",     64'(y1), exp_y(1));
        check("u1_tile",  64'(t1), exp_field(1, 0));
        check("u1_laps",  64'(l1), exp_field(1, 1));
        check("u1_fin",   64'(f1), exp_field(1, 2));
    endtask

    // Drive one cycle of inputs, advance the model, then sample after the edge.
    task automatic cycle(bit v, int pl, int st, bit tk);
        move_valid = v;
        mp         = 2'(pl);
        move_steps = 4'(st);
        frame_tick = tk;
        model_step(0, v, pl, st, tk);
        model_step(1, v, pl, st, tk);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic run_ticks(int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 0, 0, 1'b1);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;

        // P0 by 1 with a tick every cycle (tick on the accept cycle is ignored).
        cycle(1'b1, 0, 1, 1'b1);
        run_ticks(45);
        check("p0_tile1", 64'(t0[3:0]), 64'd1);
        check("p0_x64",   64'(x0[9:0]), 64'd64);

        // P1 by 3; P0 must stay put.
        cycle(1'b1, 1, 3, 1'b1);
        run_ticks(125);
        check("p1_tile3", 64'(t0[7:4]),   64'd3);
        check("p1_x160",  64'(x0[19:10]), 64'd160);
        check("p0_keep",  64'(x0[9:0]),   64'd64);

        // P0 to tile 8, then 3 more: wraps on u0, clamps at 9 on u1.
        cycle(1'b1, 0, 7, 1'b1);
        run_ticks(290);
        cycle(1'b1, 0, 3, 1'b1);
        run_ticks(130);
        check("wrap_tile", 64'(t0[3:0]), 64'd1);
        check("wrap_lap",  64'(l0[3:0]), 64'd1);
        check("clamp_tile", 64'(t1[3:0]), 64'd9);
        check("clamp_fin",  64'(f1[0]),   64'd1);

        // Finished token: immediate done on u1, normal move on u0.
        cycle(1'b1, 0, 2, 1'b1);
        check("fin_done", 64'(d1), 64'd1);
        check("u0_moving", 64'(b0), 64'd1);
        run_ticks(100);

        // Zero steps completes on the next cycle.
        cycle(1'b1, 0, 0, 1'b0);
        check("zero_done", 64'(d0), 64'd1);
        cycle(1'b0, 0, 0, 1'b0);

        // Index 3 is out of range on u1 only.
        cycle(1'b1, 3, 1, 1'b0);
        check("bad_err", 64'(e1), 64'd1);
        check("bad_act", 64'(a1), 64'd3);
        // Valid held while busy, no ticks, then ticks resume.
        for (int k = 0; k < 10; k++) cycle(1'b1, 0, 1, 1'b0);
        for (int k = 0; k < 60; k++) cycle(1'b1, 0, 1, 1'b1);
        cycle(1'b0, 0, 0, 1'b0);
        run_ticks(90);

        // Asynchronous reset in the middle of a slide.
        cycle(1'b1, 1, 2, 1'b0);
        for (int k = 0; k < 10; k++) cycle(1'b0, 0, 0, 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst_x",  64'(x0), {44'd0, 10'd16, 10'd16});
        check("rst_busy", 64'(b0), 64'd0);
        check("rst_ready", 64'(r0), 64'd1);
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;

        // Randomized commands and frame ticks.
        for (int k = 0; k < 15000; k++) begin
            cycle(($urandom_range(3) == 0), int'($urandom_range(3)),
                  int'($urandom_range(15)), ($urandom_range(1) == 1));
        end

        finish_run();
    end

endmodule
